vga_frame_capture: RTL and testbench

- Receive end of the VGA pixel interface: samples the r/g/b/hs/vs/blank_n stream produced by the display pipeline.
- On request, captures exactly one active frame.
- Writes each pixel as a 32-bit word into DDR3 through an Avalon-MM write master, so HPS software can read back and check displayed frames.
- Sits inside the FPGA fabric next to the VGA output block on the 100 MHz clock, behind the same register/status path as test_regs.

---
 rtl/vga_frame_capture.sv | 173 +++++++++++++++++
 tb/tb_vga_frame_capture.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// Captures one active VGA frame on request and writes each pixel as a 32-bit word to memory through an Avalon-MM write master.
// Optional VGA_CAPTURE_CHECKSUM_EN adds the frame_sum and hs_count outputs.
module vga_frame_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [7:0]        vga_r,
    input  logic [7:0]        vga_g,
    input  logic [7:0]        vga_b,
    input  logic              vga_hs,
    input  logic              vga_vs,
    input  logic              vga_blank_n,
    input  logic              cap_start,
    input  logic [ADDR_W-1:0] cap_base,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              short_frame,
    output logic [19:0]       pix_count,
`ifdef VGA_CAPTURE_CHECKSUM_EN
    output logic [31:0]       frame_sum,
    output logic [15:0]       hs_count,
`endif
    output logic [2:0]        fsm_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [19:0] LAST_PIX = 20'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic              vs_q;
    logic [ADDR_W-1:0] base_q;

    // Each FIFO entry carries its pixel index, so dropped pixels leave holes instead of shifting addresses.
    logic [23:0]       mem_data [FIFO_DEPTH];
    logic [19:0]       mem_idx  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic fs_event;
    logic pix_in;
    logic full;
    logic push;
    logic pop;
    logic start_ok;

    assign fs_event = pix_en & vs_q & ~vga_vs;
    assign pix_in   = (state == CAPTURE) & pix_en & vga_blank_n & ~fs_event;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push     = pix_in & ~full;
    assign pop      = avm_write & ~avm_waitrequest;
    assign start_ok = cap_start & ((state == IDLE) | (state == DONE));

    assign avm_write     = (count != '0);
    assign avm_writedata = {8'h00, mem_data[rd_ptr]};
    assign avm_address   = base_q + ADDR_W'({mem_idx[rd_ptr], 2'b00});
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            vs_q        <= 1'b1;
            base_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            pix_count   <= '0;
        end else begin
            if (pix_en) vs_q <= vga_vs;
            case (state)
                IDLE, DONE: begin
                    if (cap_start) begin
                        base_q      <= cap_base;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                        short_frame <= 1'b0;
                        pix_count   <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_VS;
                    end
                end
                WAIT_VS: if (fs_event) state <= CAPTURE;
                CAPTURE: begin
                    if (fs_event) begin
                        short_frame <= 1'b1;
                        state       <= DRAIN;
                    end else if (pix_in) begin
                        pix_count <= pix_count + 20'd1;
                        if (full) overflow <= 1'b1;
                        if (pix_count == LAST_PIX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= {vga_r, vga_g, vga_b};
            mem_idx[wr_ptr]  <= pix_count;
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic hs_q;

    // The sum includes pixels dropped on overflow, so it reflects what was displayed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q      <= 1'b1;
            frame_sum <= '0;
            hs_count  <= '0;
        end else begin
            if (pix_en) hs_q <= vga_hs;
            if (start_ok) begin
                frame_sum <= '0;
                hs_count  <= '0;
            end else if (state == CAPTURE) begin
                if (pix_in) frame_sum <= frame_sum + {8'h00, vga_r, vga_g, vga_b};
                if (pix_en & hs_q & ~vga_hs) hs_count <= hs_count + 16'd1;
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = vga_hs ^ start_ok;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomized self-checking bench for vga_frame_capture (4x2 frame, 4-entry FIFO); expected writes come from a pixel-index address model.
module tb_vga_frame_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NP = H * V;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
    logic        cap_start = 1'b0;
    logic [31:0] cap_base = '0;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        busy, done, overflow, short_frame;
    logic [19:0] pix_count;
    logic [2:0]  fsm_state;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [31:0] frame_sum;
    logic [15:0] hs_count;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [23:0] pix[NP];
    bit          wr_force = 1'b0;
    bit          stall_en = 1'b0;
    logic [31:0] stall_addr = '0;
    logic [31:0] stall_data = '0;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          idle_lo = 0;
    int          idle_hi = 2;

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .cap_start(cap_start), .cap_base(cap_base),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .overflow(overflow), .short_frame(short_frame),
        .pix_count(pix_count),
`ifdef VGA_CAPTURE_CHECKSUM_EN
        .frame_sum(frame_sum), .hs_count(hs_count),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest = wr_force |
        (stall_en & avm_write & (avm_address == stall_addr) & (stall_left != 0));

    // Scoreboard: each accepted write must be the next expected {address, data}.
    always @(negedge clk) begin
        bit   wr_now;
        logic [63:0] e;
        if (stall_en && avm_write && avm_address == stall_addr && stall_left != 0) begin
            n_checks++;
            if (avm_writedata !== stall_data) begin
                n_fail++;
                $display("FAIL stall_hold: data %08h required %08h", avm_writedata, stall_data);
            end
            stall_left--;
            stall_seen++;
        end
        wr_now = wr_force || (stall_en && avm_address == stall_addr && stall_left != 0);
        if (avm_write && !wr_now) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %08h data %08h", avm_address, avm_writedata);
            end else begin
                e = exp_q.pop_front();
                if ({avm_address, avm_writedata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got %08h/%08h required %08h/%08h",
                             avm_address, avm_writedata, e[63:32], e[31:0]);
                end
            end
        end
    end

    function automatic void build_exp(input logic [31:0] base, input int n_keep);
        for (int k = 0; k < n_keep; k++) exp_q.push_back({base + 32'(4 * k), 8'h00, pix[k]});
    endfunction

    function automatic logic [31:0] pix_sum(input int n);
        logic [31:0] s = '0;
        for (int k = 0; k < n; k++) s += {8'h00, pix[k]};
        return s;
    endfunction

    task automatic slot(input logic vs, input logic hs, input logic bn, input logic [23:0] rgb);
        repeat ($urandom_range(idle_hi, idle_lo)) begin
            pix_en = 1'b0;
            {vga_r, vga_g, vga_b} = 24'($urandom());
            vga_blank_n = 1'($urandom());
            vga_vs = 1'($urandom());
            vga_hs = 1'($urandom());
            @(posedge clk); #1;
        end
        pix_en = 1'b1;
        vga_vs = vs;
        vga_hs = hs;
        vga_blank_n = bn;
        {vga_r, vga_g, vga_b} = rgb;
        @(posedge clk); #1;
        pix_en = 1'b0;
        vga_vs = 1'b1;
        vga_hs = 1'b1;
    endtask

    // One frame: preamble (with a stray active pixel), vs fall, V lines of hs fall + H pixels.
    task automatic send_frame(input int cut, input bit mid_start, input logic [31:0] mid_base);
        int n = 0;
        logic [31:0] keep;
        slot(1'b1, 1'b1, 1'b0, 24'h0);
        slot(1'b1, 1'b1, 1'b1, 24'hABCDEF);
        slot(1'b0, 1'b1, 1'b0, 24'h0);
        for (int l = 0; l < V; l++) begin
            slot(1'b1, 1'b0, 1'b0, 24'h0);
            slot(1'b1, 1'b1, 1'b0, 24'h0);
            for (int p = 0; p < H; p++) begin
                if (n == cut) slot(1'b0, 1'b1, 1'b0, 24'h0);
                if (mid_start && n == 3) begin
                    keep = cap_base;
                    cap_base = mid_base;
                    cap_start = 1'b1;
                end
                slot(1'b1, 1'b1, 1'b1, pix[n]);
                if (mid_start && n == 3) begin
                    cap_start = 1'b0;
                    cap_base = keep;
                end
                n++;
            end
            slot(1'b1, 1'b1, 1'b0, 24'h0);
        end
        slot(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic start_capture(input logic [31:0] base);
        cap_base = base;
        cap_start = 1'b1;
        @(posedge clk); #1;
        cap_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({avm_write, busy, done, overflow, short_frame} !== 5'b0 || pix_count !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b/%0d required 00000/0",
                     {avm_write, busy, done, overflow, short_frame}, pix_count);
        end
`ifdef VGA_CAPTURE_CHECKSUM_EN
        n_checks++;
        if (frame_sum !== 32'd0 || hs_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_sum: got %0d/%0d required 0/0", frame_sum, hs_count);
        end
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_end(input string name, input int n_pix, input bit ovf, input bit shrt, input int n_sum);
        bit ok;
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: done never set within 400 cycles, required 1", name);
        end
        n_checks++;
        if (pix_count !== 20'(n_pix) || overflow !== ovf || short_frame !== shrt || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_status: pix_count %0d ovf %b short %b busy %b required %0d %b %b 0",
                     name, pix_count, overflow, short_frame, busy, n_pix, ovf, shrt);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d expected writes missing, required 0", name, exp_q.size());
        end
`ifdef VGA_CAPTURE_CHECKSUM_EN
        n_checks++;
        if (frame_sum !== pix_sum(n_sum) || hs_count !== 16'd2) begin
            n_fail++;
            $display("FAIL %s_sum: got %0d/%0d required %0d/2", name, frame_sum, hs_count, pix_sum(n_sum));
        end
`endif
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        for (int k = 0; k < NP; k++) pix[k] = 24'(k + 1);
        build_exp(32'h1000, NP);
        start_capture(32'h1000);
        send_frame(-1, 1'b0, 32'h0);
        check_end("basic", NP, 1'b0, 1'b0, NP);
    endtask

    task automatic test_waitrequest;
        for (int k = 0; k < NP; k++) pix[k] = 24'(k + 1);
        idle_lo = 2;
        idle_hi = 3;
        stall_addr = 32'h1008;
        stall_data = 32'h3;
        stall_left = 5;
        stall_seen = 0;
        stall_en = 1'b1;
        build_exp(32'h1000, NP);
        start_capture(32'h1000);
        send_frame(-1, 1'b0, 32'h0);
        check_end("waitreq", NP, 1'b0, 1'b0, NP);
        stall_en = 1'b0;
        idle_lo = 0;
        idle_hi = 2;
        n_checks++;
        if (stall_seen != 5) begin
            n_fail++;
            $display("FAIL stall_cycles: held %0d cycles required 5", stall_seen);
        end
    endtask

    task automatic test_overflow;
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom());
        build_exp(32'h4000, 4);
        wr_force = 1'b1;
        start_capture(32'h4000);
        send_frame(-1, 1'b0, 32'h0);
        n_checks++;
        if (overflow !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_stalled: overflow %b done %b required 1 0", overflow, done);
        end
        wr_force = 1'b0;
        check_end("overflow", NP, 1'b1, 1'b0, NP);
    endtask

    task automatic test_short_frame;
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom());
        build_exp(32'h8000_0000, 5);
        start_capture(32'h8000_0000);
        send_frame(5, 1'b0, 32'h0);
        check_end("short", 5, 1'b0, 1'b1, 5);
    endtask

    task automatic test_ignore_start;
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom());
        build_exp(32'h2000, NP);
        start_capture(32'h2000);
        send_frame(-1, 1'b1, 32'h9000);
        check_end("ignore", NP, 1'b0, 1'b0, NP);
    endtask

    task automatic test_back_to_back;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pre_done: done %b required 1", done);
        end
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom());
        build_exp(32'hFFFF_FFF8, NP);
        start_capture(32'hFFFF_FFF8);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || pix_count !== 20'd0) begin
            n_fail++;
            $display("FAIL b2b_rearm: done %b busy %b pix_count %0d required 0 1 0", done, busy, pix_count);
        end
        @(posedge clk); #1;
        send_frame(-1, 1'b0, 32'h0);
        check_end("b2b_wrap", NP, 1'b0, 1'b0, NP);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom());
        wr_force = 1'b1;
        start_capture(32'h3000);
        slot(1'b1, 1'b1, 1'b0, 24'h0);
        slot(1'b0, 1'b1, 1'b0, 24'h0);
        slot(1'b1, 1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 3; k++) slot(1'b1, 1'b1, 1'b1, pix[k]);
        n_checks++;
        if (avm_write !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: avm_write %b busy %b required 1 1", avm_write, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || pix_count !== 20'd0) begin
            n_fail++;
            $display("FAIL mid_reset: avm_write %b busy %b pix_count %0d required 0 0 0",
                     avm_write, busy, pix_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        wr_force = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: avm_write %b busy %b done %b required 0 0 0", avm_write, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_overflow();
        test_short_frame();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
